c_frag_rr_sched: RTL and testbench

Round-robin scheduler that time-shares one C_FRAG logic fragment among NREQ requesters. It accepts one requester's 13-bit select/data vector, drives it onto the fragment, and waits SETTLE_CYC cycles for routing to settle. It then captures TZ/CZ and returns them, tagged with the requester ID, through a ready/valid response port. It sits between soft-logic clients and a shared PP3 logic cell in the same clock domain.

---
 rtl/c_frag_rr_sched_if.sv | 29 ++
 rtl/c_frag_rr_sched.sv | 136 +++++++++++++
 tb/tb_c_frag_rr_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/c_frag_rr_sched_if.sv
// Bundle of request, fragment and response signals for the shared C_FRAG scheduler.
// The scheduler uses the slave view. Clients and the fragment use the master view.
interface c_frag_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic [NREQ-1:0]      REQ_VALID;
  logic [NREQ-1:0]      REQ_READY;
  logic [13*NREQ-1:0]   REQ_SEL;
  logic [12:0]          FRAG_IN;
  logic                 FRAG_TZ;
  logic                 FRAG_CZ;
  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [IDW-1:0]       RSP_ID;
  logic                 RSP_TZ;
  logic                 RSP_CZ;
  logic                 BUSY;

  modport slave (
    input  REQ_VALID, REQ_SEL, FRAG_TZ, FRAG_CZ, RSP_READY,
    output REQ_READY, FRAG_IN, RSP_VALID, RSP_ID, RSP_TZ, RSP_CZ, BUSY
  );

  modport master (
    output REQ_VALID, REQ_SEL, FRAG_TZ, FRAG_CZ, RSP_READY,
    input  REQ_READY, FRAG_IN, RSP_VALID, RSP_ID, RSP_TZ, RSP_CZ, BUSY
  );
endinterface

// File: rtl/c_frag_rr_sched.sv
// Round-robin time-sharing of one C_FRAG among NREQ requesters.
// Each grant drives the fragment, waits for it to settle, then returns TZ/CZ with the requester ID.
module c_frag_rr_sched #(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 1,
  parameter int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             QCK,
  input  logic             QRTN,
  c_frag_rr_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  state_t         state_reg, state_next;
  logic [IDW-1:0] ptr_reg, ptr_next;
  logic [IDW-1:0] id_reg, id_next;
  logic [3:0]     cnt_reg, cnt_next;
  logic [12:0]    frag_in_reg, frag_in_next;
  logic           rsp_valid_reg, rsp_valid_next;
  logic [IDW-1:0] rsp_id_reg, rsp_id_next;
  logic           rsp_tz_reg, rsp_tz_next;
  logic           rsp_cz_reg, rsp_cz_next;

  logic [12:0]    sel_arr [NREQ];
  logic           grant_found;
  logic [IDW-1:0] grant_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign sel_arr[gi] = bus.REQ_SEL[13*gi +: 13];
  end

  // Scan downward so the candidate closest to the pointer is the last one written.
  always_comb begin
    int             cand;
    logic [IDW-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = int'(ptr_reg) + k;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cand_idx = IDW'(cand);
      if (bus.REQ_VALID[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // Gated by QRTN so no grant is advertised while reset is held.
  always_comb begin
    bus.REQ_READY = '0;
    if ((state_reg == IDLE) && grant_found && QRTN) begin
      bus.REQ_READY[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    id_next        = id_reg;
    cnt_next       = cnt_reg;
    frag_in_next   = frag_in_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_id_next    = rsp_id_reg;
    rsp_tz_next    = rsp_tz_reg;
    rsp_cz_next    = rsp_cz_reg;
    unique case (state_reg)
      IDLE: begin
        if (grant_found) begin
          frag_in_next = sel_arr[grant_idx];
          id_next      = grant_idx;
          ptr_next     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
          cnt_next     = 4'(SETTLE_CYC - 1);
          state_next   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_reg == 4'd0) begin
          rsp_tz_next    = bus.FRAG_TZ;
          rsp_cz_next    = bus.FRAG_CZ;
          rsp_id_next    = id_reg;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if (bus.RSP_READY) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge QCK or negedge QRTN) begin
    if (!QRTN) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      id_reg        <= '0;
      cnt_reg       <= 4'd0;
      frag_in_reg   <= 13'd0;
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
      rsp_tz_reg    <= 1'b0;
      rsp_cz_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      id_reg        <= id_next;
      cnt_reg       <= cnt_next;
      frag_in_reg   <= frag_in_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_id_reg    <= rsp_id_next;
      rsp_tz_reg    <= rsp_tz_next;
      rsp_cz_reg    <= rsp_cz_next;
    end
  end

  assign bus.FRAG_IN   = frag_in_reg;
  assign bus.RSP_VALID = rsp_valid_reg;
  assign bus.RSP_ID    = rsp_id_reg;
  assign bus.RSP_TZ    = rsp_tz_reg;
  assign bus.RSP_CZ    = rsp_cz_reg;
  assign bus.BUSY      = (state_reg != IDLE);

endmodule

// File: tb/tb_c_frag_rr_sched.sv
// Directed bench for c_frag_rr_sched: one SETTLE_CYC=1 and one SETTLE_CYC=3 instance
// sharing clock and reset, each fed by a bench model of an uninverted C_FRAG.
module tb_c_frag_rr_sched;

  logic QCK  = 1'b0;
  logic QRTN = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic tz_ovr_en  = 1'b0;
  logic tz_ovr_val = 1'b0;

  always #5 QCK = ~QCK;

  c_frag_rr_sched_if #(.NREQ(4)) bus1 ();
  c_frag_rr_sched_if #(.NREQ(4)) bus3 ();

  c_frag_rr_sched #(.NREQ(4), .SETTLE_CYC(1)) dut1 (.QCK(QCK), .QRTN(QRTN), .bus(bus1.slave));
  c_frag_rr_sched #(.NREQ(4), .SETTLE_CYC(3)) dut3 (.QCK(QCK), .QRTN(QRTN), .bus(bus3.slave));

  // C_FRAG with every inversion parameter at 0.
  function automatic logic model_tz(input logic [12:0] f);
    logic tai, tbi;
    tai = f[10] ? f[8] : f[9];
    tbi = f[10] ? f[6] : f[7];
    return f[11] ? tbi : tai;
  endfunction

  function automatic logic model_cz(input logic [12:0] f);
    logic bai, bbi, czi;
    bai = f[4] ? f[2] : f[3];
    bbi = f[4] ? f[0] : f[1];
    czi = f[5] ? bbi : bai;
    return f[12] ? czi : model_tz(f);
  endfunction

  assign bus1.FRAG_TZ = model_tz(bus1.FRAG_IN);
  assign bus1.FRAG_CZ = model_cz(bus1.FRAG_IN);
  assign bus3.FRAG_TZ = tz_ovr_en ? tz_ovr_val : model_tz(bus3.FRAG_IN);
  assign bus3.FRAG_CZ = model_cz(bus3.FRAG_IN);

  task automatic tick();
    @(posedge QCK);
    #1;
  endtask

  task automatic do_reset();
    QRTN = 1'b0;
    tick();
    QRTN = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    QRTN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus1.REQ_VALID = 4'($urandom) | 4'b0001;
      bus1.REQ_SEL   = 52'({$urandom, $urandom});
      bus1.RSP_READY = 1'($urandom);
      bus3.REQ_VALID = 4'($urandom) | 4'b0010;
      bus3.REQ_SEL   = 52'({$urandom, $urandom});
      bus3.RSP_READY = 1'($urandom);
      tick();
      #1;
      n_tests++;
      if ({bus1.REQ_READY, bus1.FRAG_IN, bus1.RSP_VALID, bus1.RSP_ID, bus1.RSP_TZ, bus1.RSP_CZ, bus1.BUSY} !== 24'd0) begin
        n_fail++;
        $display("FAIL reset_hold_dut1: got %h want 0", {bus1.REQ_READY, bus1.FRAG_IN, bus1.RSP_VALID, bus1.RSP_ID, bus1.RSP_TZ, bus1.RSP_CZ, bus1.BUSY});
      end
      n_tests++;
      if ({bus3.REQ_READY, bus3.FRAG_IN, bus3.RSP_VALID, bus3.RSP_ID, bus3.RSP_TZ, bus3.RSP_CZ, bus3.BUSY} !== 24'd0) begin
        n_fail++;
        $display("FAIL reset_hold_dut3: got %h want 0", {bus3.REQ_READY, bus3.FRAG_IN, bus3.RSP_VALID, bus3.RSP_ID, bus3.RSP_TZ, bus3.RSP_CZ, bus3.BUSY});
      end
    end
    bus1.REQ_VALID = '0;
    bus3.REQ_VALID = '0;
    bus1.RSP_READY = 1'b1;
    bus3.RSP_READY = 1'b1;
    tick();
    QRTN = 1'b1;
    tick();
    // Get into SETTLE, then pull reset asynchronously mid-cycle.
    bus1.REQ_SEL   = {13'h0000, 13'h0000, 13'h0000, 13'h1FFF};
    bus1.REQ_VALID = 4'b0001;
    tick();
    bus1.REQ_VALID = '0;
    #1;
    n_tests++;
    if (bus1.BUSY !== 1'b1 || bus1.FRAG_IN !== 13'h1FFF) begin
      n_fail++;
      $display("FAIL reset_pre_busy: got busy=%b frag=%h want busy=1 frag=1fff", bus1.BUSY, bus1.FRAG_IN);
    end
    #1;
    QRTN = 1'b0;
    #1;
    n_tests++;
    if (bus1.BUSY !== 1'b0 || bus1.FRAG_IN !== 13'h0000 || bus1.RSP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: got busy=%b frag=%h rsp_valid=%b want 0 0 0", bus1.BUSY, bus1.FRAG_IN, bus1.RSP_VALID);
    end
    tick();
    QRTN = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus1.REQ_SEL   = {13'h0200, 13'h1022, 13'h0C40, 13'h0001};
    bus1.RSP_READY = 1'b1;
    bus1.REQ_VALID = 4'b0100;
    #1;
    n_tests++;
    if (bus1.REQ_READY !== 4'b0100 || bus1.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: got ready=%b busy=%b want ready=0100 busy=0", bus1.REQ_READY, bus1.BUSY);
    end
    tick();
    bus1.REQ_VALID = '0;
    #1;
    n_tests++;
    if (bus1.REQ_READY !== 4'b0000 || bus1.FRAG_IN !== 13'h1022 || bus1.RSP_VALID !== 1'b0 || bus1.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL single_settle: got ready=%b frag=%h rsp_valid=%b busy=%b want 0000 1022 0 1",
               bus1.REQ_READY, bus1.FRAG_IN, bus1.RSP_VALID, bus1.BUSY);
    end
    tick();
    #1;
    n_tests++;
    if (bus1.RSP_VALID !== 1'b1 || bus1.RSP_ID !== 2'd2 || bus1.RSP_CZ !== 1'b1 || bus1.RSP_TZ !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: got valid=%b id=%0d cz=%b tz=%b want 1 2 1 0",
               bus1.RSP_VALID, bus1.RSP_ID, bus1.RSP_CZ, bus1.RSP_TZ);
    end
    tick();
    #1;
    n_tests++;
    if (bus1.RSP_VALID !== 1'b0 || bus1.BUSY !== 1'b0 || bus1.FRAG_IN !== 13'h1022) begin
      n_fail++;
      $display("FAIL single_idle: got valid=%b busy=%b frag=%h want 0 0 1022", bus1.RSP_VALID, bus1.BUSY, bus1.FRAG_IN);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_tz;
    logic [3:0] exp_cz;
    logic [3:0] exp_ready;
    int         id;
    exp_tz = 4'b1010;
    exp_cz = 4'b1110;
    do_reset();
    bus1.REQ_SEL   = {13'h0200, 13'h1022, 13'h0C40, 13'h0001};
    bus1.RSP_READY = 1'b1;
    bus1.REQ_VALID = 4'b1111;
    for (int c = 0; c < 15; c++) begin
      #1;
      id        = (c / 3) % 4;
      exp_ready = (c % 3 == 0) ? (4'b0001 << id) : 4'b0000;
      n_tests++;
      if (bus1.REQ_READY !== exp_ready) begin
        n_fail++;
        $display("FAIL rr_ready c=%0d: got %b want %b", c, bus1.REQ_READY, exp_ready);
      end
      if (c % 3 == 2) begin
        n_tests++;
        if (bus1.RSP_VALID !== 1'b1 || bus1.RSP_ID !== 2'(id) || bus1.RSP_TZ !== exp_tz[id] || bus1.RSP_CZ !== exp_cz[id]) begin
          n_fail++;
          $display("FAIL rr_resp c=%0d: got valid=%b id=%0d tz=%b cz=%b want 1 %0d %b %b",
                   c, bus1.RSP_VALID, bus1.RSP_ID, bus1.RSP_TZ, bus1.RSP_CZ, id, exp_tz[id], exp_cz[id]);
        end
      end else begin
        n_tests++;
        if (bus1.RSP_VALID !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_novalid c=%0d: got %b want 0", c, bus1.RSP_VALID);
        end
      end
      tick();
    end
    bus1.REQ_VALID = '0;
  endtask

  task automatic test_backpressure();
    bus1.RSP_READY = 1'b0;
    bus1.REQ_VALID = 4'b0011;
    #1;
    n_tests++;
    if (bus1.REQ_READY !== 4'b0010) begin
      n_fail++;
      $display("FAIL bp_grant: got %b want 0010", bus1.REQ_READY);
    end
    tick();
    tick();
    bus1.REQ_SEL = {13'h0200, 13'h1022, 13'h0000, 13'h0001};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_tests++;
      if (bus1.RSP_VALID !== 1'b1 || bus1.RSP_ID !== 2'd1 || bus1.RSP_TZ !== 1'b1 || bus1.RSP_CZ !== 1'b1 ||
          bus1.REQ_READY !== 4'b0000 || bus1.BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold i=%0d: got valid=%b id=%0d tz=%b cz=%b ready=%b busy=%b want 1 1 1 1 0000 1",
                 i, bus1.RSP_VALID, bus1.RSP_ID, bus1.RSP_TZ, bus1.RSP_CZ, bus1.REQ_READY, bus1.BUSY);
      end
      tick();
    end
    bus1.RSP_READY = 1'b1;
    #1;
    n_tests++;
    if (bus1.RSP_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_valid: got %b want 1", bus1.RSP_VALID);
    end
    tick();
    #1;
    n_tests++;
    if (bus1.BUSY !== 1'b0 || bus1.RSP_VALID !== 1'b0 || bus1.REQ_READY !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_idle: got busy=%b valid=%b ready=%b want 0 0 0001", bus1.BUSY, bus1.RSP_VALID, bus1.REQ_READY);
    end
    tick();
    bus1.REQ_VALID = '0;
    #1;
    n_tests++;
    if (bus1.FRAG_IN !== 13'h0001) begin
      n_fail++;
      $display("FAIL bp_next_frag: got %h want 0001", bus1.FRAG_IN);
    end
    tick();
    tick();
    bus1.REQ_SEL = {13'h0200, 13'h1022, 13'h0C40, 13'h0001};
  endtask

  task automatic test_settle3();
    bus3.REQ_SEL   = {13'h0000, 13'h0000, 13'h0000, 13'h0C40};
    bus3.RSP_READY = 1'b1;
    bus3.REQ_VALID = 4'b0001;
    tz_ovr_en      = 1'b1;
    tz_ovr_val     = 1'b0;
    #1;
    n_tests++;
    if (bus3.REQ_READY !== 4'b0001) begin
      n_fail++;
      $display("FAIL s3_grant: got %b want 0001", bus3.REQ_READY);
    end
    tick();
    bus3.REQ_VALID = '0;
    bus3.REQ_SEL   = {13'h0000, 13'h0000, 13'h0000, 13'h0003};
    for (int s = 1; s <= 3; s++) begin
      tz_ovr_val = (s < 3);
      #1;
      n_tests++;
      if (bus3.FRAG_IN !== 13'h0C40 || bus3.RSP_VALID !== 1'b0 || bus3.BUSY !== 1'b1 || bus3.REQ_READY !== 4'b0000) begin
        n_fail++;
        $display("FAIL s3_settle s=%0d: got frag=%h valid=%b busy=%b ready=%b want 0c40 0 1 0000",
                 s, bus3.FRAG_IN, bus3.RSP_VALID, bus3.BUSY, bus3.REQ_READY);
      end
      tick();
    end
    #1;
    n_tests++;
    if (bus3.RSP_VALID !== 1'b1 || bus3.RSP_TZ !== 1'b0 || bus3.RSP_CZ !== 1'b1 || bus3.RSP_ID !== 2'd0) begin
      n_fail++;
      $display("FAIL s3_resp: got valid=%b tz=%b cz=%b id=%0d want 1 0 1 0",
               bus3.RSP_VALID, bus3.RSP_TZ, bus3.RSP_CZ, bus3.RSP_ID);
    end
    tz_ovr_en = 1'b0;
    tick();
    #1;
    n_tests++;
    if (bus3.BUSY !== 1'b0 || bus3.RSP_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL s3_idle: got busy=%b valid=%b want 0 0", bus3.BUSY, bus3.RSP_VALID);
    end
  endtask

  task automatic test_reset_mid();
    bus1.RSP_READY = 1'b1;
    bus1.REQ_VALID = 4'b0100;
    #1;
    n_tests++;
    if (bus1.REQ_READY !== 4'b0100) begin
      n_fail++;
      $display("FAIL rm_grant: got %b want 0100", bus1.REQ_READY);
    end
    tick();
    bus1.REQ_VALID = '0;
    #1;
    QRTN = 1'b0;
    #1;
    n_tests++;
    if (bus1.BUSY !== 1'b0 || bus1.FRAG_IN !== 13'h0000) begin
      n_fail++;
      $display("FAIL rm_clear: got busy=%b frag=%h want 0 0000", bus1.BUSY, bus1.FRAG_IN);
    end
    tick();
    QRTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (bus1.RSP_VALID !== 1'b0 || bus1.BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL rm_noresp i=%0d: got valid=%b busy=%b want 0 0", i, bus1.RSP_VALID, bus1.BUSY);
      end
      tick();
    end
    bus1.REQ_VALID = 4'b1111;
    #1;
    n_tests++;
    if (bus1.REQ_READY !== 4'b0001) begin
      n_fail++;
      $display("FAIL rm_ptr_reset: got %b want 0001", bus1.REQ_READY);
    end
    tick();
    bus1.REQ_VALID = '0;
    #1;
    n_tests++;
    if (bus1.FRAG_IN !== 13'h0001) begin
      n_fail++;
      $display("FAIL rm_frag: got %h want 0001", bus1.FRAG_IN);
    end
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus1.REQ_VALID = '0;
    bus1.REQ_SEL   = '0;
    bus1.RSP_READY = 1'b1;
    bus3.REQ_VALID = '0;
    bus3.REQ_SEL   = '0;
    bus3.RSP_READY = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_settle3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
